// File: rtl/decoder_pkg.sv
// =============================================================================
// Module  : decoder_pkg
// Brief   : Shared state encoding and mode constants for decoder_scan_n.
// Revision: 1.0
// =============================================================================
`default_nettype none

package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        BLANK  = 2'd3
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/decoder_scan_n_if.sv
// =============================================================================
// Module  : decoder_scan_n_if
// Brief   : Control/select handshake and decoded-output bundle of decoder_scan_n.
// Revision: 1.0
// =============================================================================
`default_nettype none

interface decoder_scan_n_if #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 2**SEL_W;

    logic               en_i;
    logic               mode_i;
    logic [SEL_W-1:0]   sel_i;
    logic               sel_valid_i;
    logic               sel_ready_o;
    logic [DWELL_W-1:0] dwell_i;
    logic [SEL_W-1:0]   last_i;
    logic [OUT_W-1:0]   y_o;
    logic [SEL_W-1:0]   idx_o;
    logic               step_o;
    logic               wrap_o;

    modport slave (
        input  en_i, mode_i, sel_i, sel_valid_i, dwell_i, last_i,
        output sel_ready_o, y_o, idx_o, step_o, wrap_o
    );

    modport master (
        output en_i, mode_i, sel_i, sel_valid_i, dwell_i, last_i,
        input  sel_ready_o, y_o, idx_o, step_o, wrap_o
    );

endinterface

`default_nettype wire

// File: rtl/onehot_dec.sv
// =============================================================================
// Module  : onehot_dec
// Brief   : Combinational SEL_W-to-2**SEL_W one-hot decoder.
// Revision: 1.0
// =============================================================================
`default_nettype none

module onehot_dec #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] y
);
    localparam int OUT_W = 2**SEL_W;

    generate
        for (genvar i = 0; i < OUT_W; i++) begin : g_bit
            assign y[i] = (sel == SEL_W'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/decoder_scan_n.sv
// =============================================================================
// Module  : decoder_scan_n
// Brief   : Registered one-hot decoder with DIRECT (handshaked) and SCAN
//           (auto-sequencing) modes. Optional macro DEC_SCAN_BLANK_EN inserts
//           BLANK_CYC all-zero cycles between scan steps.
// Revision: 1.0
// =============================================================================
`default_nettype none

module decoder_scan_n #(
    parameter int SEL_W     = 4,
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    decoder_scan_n_if.slave bus
);
    import decoder_pkg::*;

    localparam int OUT_W = 2**SEL_W;
    localparam int BLK_W = $clog2(BLANK_CYC + 1);
    localparam int CNT_W = (DWELL_W > BLK_W) ? DWELL_W : BLK_W;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SEL_W-1:0]   idx, idx_nxt;
    logic [OUT_W-1:0]   y, y_nxt;
    logic               step, step_nxt;
    logic               wrap, wrap_nxt;

    logic [SEL_W-1:0]   dec_sel;
    logic [OUT_W-1:0]   dec_y;
    logic [SEL_W-1:0]   scan_nxt;
    logic               scan_wrap;
    logic [DWELL_W-1:0] dwell_m1;
    logic               dwell_end;
    logic               exit_direct;
    logic               exit_scan;

    // Dwell of 0 behaves as 1; compare with >= so a live shrink ends the hold at once.
    assign dwell_m1  = (bus.dwell_i == '0) ? '0 : bus.dwell_i - DWELL_W'(1);
    assign dwell_end = (cnt >= CNT_W'(dwell_m1));

    assign scan_wrap = (idx >= bus.last_i);
    assign scan_nxt  = scan_wrap ? '0 : idx + SEL_W'(1);

    assign exit_direct = ~bus.en_i | (bus.mode_i != MODE_DIRECT);
    assign exit_scan   = ~bus.en_i | (bus.mode_i != MODE_SCAN);

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .sel (dec_sel),
        .y   (dec_y)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        y_nxt     = y;
        step_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        dec_sel   = scan_nxt;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                y_nxt   = '0;
                if (bus.en_i) begin
                    if (bus.mode_i == MODE_SCAN) begin
                        state_nxt = SCAN;
                        dec_sel   = '0;
                        y_nxt     = dec_y;
                        step_nxt  = 1'b1;
                    end else begin
                        state_nxt = DIRECT;
                    end
                end
            end

            DIRECT: begin
                dec_sel = bus.sel_i;
                // Exit wins over a coincident handshake.
                if (exit_direct) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    y_nxt     = '0;
                end else if (bus.sel_valid_i) begin
                    idx_nxt = bus.sel_i;
                    y_nxt   = dec_y;
                end
            end

            SCAN: begin
                if (exit_scan) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    y_nxt     = '0;
                end else if (dwell_end) begin
                    cnt_nxt = '0;
`ifdef DEC_SCAN_BLANK_EN
                    state_nxt = BLANK;
                    y_nxt     = '0;
`else
                    idx_nxt  = scan_nxt;
                    y_nxt    = dec_y;
                    step_nxt = 1'b1;
                    wrap_nxt = scan_wrap;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

`ifdef DEC_SCAN_BLANK_EN
            BLANK: begin
                // idx keeps the previous index so last_i is still sampled live at blank end.
                if (exit_scan) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    y_nxt     = '0;
                end else if (cnt >= CNT_W'(BLANK_CYC - 1)) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                    idx_nxt   = scan_nxt;
                    y_nxt     = dec_y;
                    step_nxt  = 1'b1;
                    wrap_nxt  = scan_wrap;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
`endif

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                y_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            y     <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            y     <= y_nxt;
            step  <= step_nxt;
            wrap  <= wrap_nxt;
        end
    end

    assign bus.sel_ready_o = (state == DIRECT);
    assign bus.y_o         = y;
    assign bus.idx_o       = idx;
    assign bus.step_o      = step;
    assign bus.wrap_o      = wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan_n.sv
// =============================================================================
// Module  : tb_decoder_scan_n
// Brief   : Self-checking bench for decoder_scan_n (honours DEC_SCAN_BLANK_EN).
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_decoder_scan_n;

    localparam int SEL_W     = 4;
    localparam int DWELL_W   = 8;
    localparam int BLANK_CYC = 2;
`ifdef DEC_SCAN_BLANK_EN
    localparam int BLK = BLANK_CYC;
`else
    localparam int BLK = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    decoder_scan_n_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    decoder_scan_n #(
        .SEL_W     (SEL_W),
        .DWELL_W   (DWELL_W),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        int          tag;
        logic        en;
        logic        mode;
        logic [3:0]  sel;
        logic        valid;
        logic [7:0]  dwell;
        logic [3:0]  last;
        logic [15:0] y;
        logic [3:0]  idx;
        logic        rdy;
        logic        step;
        logic        wrap;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input int tag, input logic en, input logic mode,
                                input logic [3:0] sel, input logic valid,
                                input logic [7:0] dwell, input logic [3:0] last,
                                input logic [15:0] y, input logic [3:0] idx,
                                input logic rdy, input logic step, input logic wrap);
        vec_t v;
        v.tag = tag;  v.en = en;     v.mode = mode; v.sel = sel;   v.valid = valid;
        v.dwell = dwell; v.last = last; v.y = y;   v.idx = idx;   v.rdy = rdy;
        v.step = step; v.wrap = wrap;
        return v;
    endfunction

    function automatic void add_idle(input int tag);
        vecs.push_back(mk(tag, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 4'd0,
                          16'h0000, 4'd0, 1'b0, 1'b0, 1'b0));
    endfunction

    // Expected scan trace from IDLE: index s held max(d,1) cycles, then BLK zero cycles.
    function automatic void add_scan(input int tag, input int d, input int last, input int n);
        int de;
        int p;
        de = (d == 0) ? 1 : d;
        p  = de + BLK;
        for (int k = 0; k < n; k++) begin
            int          s;
            int          r;
            int          ix;
            logic [15:0] yy;
            logic        st;
            s  = k / p;
            r  = k % p;
            ix = s % (last + 1);
            yy = (r < de) ? (16'd1 << ix) : 16'd0;
            st = (r == 0);
            vecs.push_back(mk(tag, 1'b1, 1'b1, 4'd0, 1'b0, 8'(d), 4'(last),
                              yy, 4'(ix), 1'b0, st, st && (s > 0) && (ix == 0)));
        end
    endfunction

    task automatic check_now(input vec_t e);
        n_vec++;
        if (bus.y_o !== e.y || bus.idx_o !== e.idx || bus.sel_ready_o !== e.rdy ||
            bus.step_o !== e.step || bus.wrap_o !== e.wrap) begin
            n_bad++;
            $display("FAIL t%0d: got y=%h idx=%h rdy=%b step=%b wrap=%b, need y=%h idx=%h rdy=%b step=%b wrap=%b",
                     e.tag, bus.y_o, bus.idx_o, bus.sel_ready_o, bus.step_o, bus.wrap_o,
                     e.y, e.idx, e.rdy, e.step, e.wrap);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        bus.en_i        = v.en;
        bus.mode_i      = v.mode;
        bus.sel_i       = v.sel;
        bus.sel_valid_i = v.valid;
        bus.dwell_i     = v.dwell;
        bus.last_i      = v.last;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_now(e);
    endtask

    initial begin
        int p;

        rst_n           = 1'b0;
        bus.en_i        = 1'b0;
        bus.mode_i      = 1'b0;
        bus.sel_i       = '0;
        bus.sel_valid_i = 1'b0;
        bus.dwell_i     = '0;
        bus.last_i      = '0;

        #7;
        check_now(mk(0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 4'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0));
        #5;
        rst_n = 1'b1;

        // DIRECT decode, hold, and extreme selects
        vecs.push_back(mk(1, 1'b1, 1'b0, 4'h0, 1'b0, 8'd0, 4'd0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1, 1'b1, 1'b0, 4'hA, 1'b1, 8'd0, 4'd0, 16'h0400, 4'hA, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1, 1'b1, 1'b0, 4'h3, 1'b0, 8'd0, 4'd0, 16'h0400, 4'hA, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1, 1'b1, 1'b0, 4'h3, 1'b0, 8'd0, 4'd0, 16'h0400, 4'hA, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1, 1'b1, 1'b0, 4'hF, 1'b1, 8'd0, 4'd0, 16'h8000, 4'hF, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1, 1'b1, 1'b0, 4'h0, 1'b1, 8'd0, 4'd0, 16'h0001, 4'h0, 1'b1, 1'b0, 1'b0));
        add_idle(1);

        // DIRECT -> SCAN with valid held: no accept on exit edge, one IDLE cycle
        vecs.push_back(mk(5, 1'b1, 1'b0, 4'h0, 1'b0, 8'd3, 4'd3, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(5, 1'b1, 1'b0, 4'h5, 1'b1, 8'd3, 4'd3, 16'h0020, 4'h5, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(5, 1'b1, 1'b1, 4'h9, 1'b1, 8'd3, 4'd3, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(5, 1'b1, 1'b1, 4'h9, 1'b1, 8'd3, 4'd3, 16'h0001, 4'h0, 1'b0, 1'b1, 1'b0));
        add_idle(5);

        // SCAN dwell=3 last=3 through one wrap
        add_scan(2, 3, 3, 4 * (3 + BLK) + 3);
        add_idle(2);

        // SCAN dwell=0 last=0
        add_scan(3, 0, 0, 6);
        add_idle(3);

        // Drop en at index 2, then restart at index 0
        add_scan(4, 2, 5, 2 * (2 + BLK) + 1);
        add_idle(4);
        add_scan(4, 2, 5, 2);
        add_idle(4);

        // last lowered below idx mid-scan wraps at next dwell end
        p = 1 + BLK;
        add_scan(7, 1, 7, 3 * p + 1);
        for (int k = 3 * p + 1; k <= 4 * p; k++) begin
            if (k < 4 * p)
                vecs.push_back(mk(7, 1'b1, 1'b1, 4'd0, 1'b0, 8'd1, 4'd1, 16'h0000, 4'd3, 1'b0, 1'b0, 1'b0));
            else
                vecs.push_back(mk(7, 1'b1, 1'b1, 4'd0, 1'b0, 8'd1, 4'd1, 16'h0001, 4'd0, 1'b0, 1'b1, 1'b1));
        end
        add_idle(7);

        // SCAN -> DIRECT switch
        add_scan(8, 3, 3, 2);
        vecs.push_back(mk(8, 1'b1, 1'b0, 4'h7, 1'b1, 8'd3, 4'd3, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(8, 1'b1, 1'b0, 4'h7, 1'b0, 8'd3, 4'd3, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(8, 1'b1, 1'b0, 4'h7, 1'b1, 8'd3, 4'd3, 16'h0080, 4'h7, 1'b1, 1'b0, 1'b0));
        add_idle(8);

`ifdef DEC_SCAN_BLANK_EN
        // Blanking: dwell=2 last=1
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0001, 4'd0, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0002, 4'd1, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0002, 4'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0000, 4'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0000, 4'd1, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(6, 1'b1, 1'b1, 4'd0, 1'b0, 8'd2, 4'd1, 16'h0001, 4'd0, 1'b0, 1'b1, 1'b1));
        add_idle(6);
`endif

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i]);

        // Async reset mid-scan clears outputs before the next edge
        apply(mk(9, 1'b1, 1'b1, 4'd0, 1'b0, 8'd3, 4'd3, 16'h0001, 4'd0, 1'b0, 1'b1, 1'b0));
        apply(mk(9, 1'b1, 1'b1, 4'd0, 1'b0, 8'd3, 4'd3, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check_now(mk(9, 1'b1, 1'b1, 4'd0, 1'b0, 8'd3, 4'd3, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(9, 1'b1, 1'b1, 4'd0, 1'b0, 8'd3, 4'd3, 16'h0001, 4'd0, 1'b0, 1'b1, 1'b0));
        apply(mk(9, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 4'd0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
